// File: rtl/crc_pkg.sv
// crc_pkg: CRC-8 constants and frame-checker state shared by the RX checker and TX generator
package crc_pkg;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} fc_state_e;
endpackage

// File: rtl/crc8_byte_update.sv
// crc8_byte_update: one-byte MSB-first CRC-8 step, no reflection
module crc8_byte_update
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);
  always_comb begin
    crc_next = crc_in ^ data;
    for (int i = 0; i < 8; i++) crc_next = crc_next[7] ? ((crc_next << 1) ^ POLY) : (crc_next << 1);
  end
endmodule

// File: rtl/uart_crc_frame_checker.sv
// uart_crc_frame_checker: validates LEN/payload/CRC-8 frames from uart_rx and forwards payload
module uart_crc_frame_checker
  import crc_pkg::*;
#(
  parameter int         MAX_LEN     = 32,
  parameter logic [7:0] CRC_POLY    = CRC8_POLY,
  parameter logic [7:0] CRC_INIT    = CRC8_INIT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] payload_data,
  output logic       payload_valid,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout,
  output logic       busy
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC - 1);
  fc_state_e state_q, state_d;
  logic [7:0] crc_q, crc_d, crc_upd, frame_len_q, frame_len_d, payload_data_q, payload_data_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic payload_valid_q, payload_valid_d, frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic crc_err_q, crc_err_d, len_err_q, len_err_d, timeout_q, timeout_d;
  logic expire, last;
  crc8_byte_update #(.POLY(CRC_POLY)) u_crc (.crc_in(crc_q), .data(rx_data), .crc_next(crc_upd));
  assign expire = !rx_valid && state_q != IDLE && idle_cnt_q == IDLE_MAX;
  assign last = (9'(byte_cnt_q) + 9'd1) == {1'b0, frame_len_q};
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = (rx_valid || state_q == IDLE || expire) ? '0 : idle_cnt_q + 1'b1;
    frame_len_d = frame_len_q;
    payload_data_d = payload_data_q;
    payload_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d = 1'b0;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    timeout_d = expire;
    if (expire) state_d = IDLE;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        frame_len_d = rx_data;
        len_err_d = rx_data == 8'd0 || rx_data > MAX_B;
        state_d = len_err_d ? IDLE : PAYLOAD;
        crc_d = CRC_INIT;
        byte_cnt_d = '0;
      end
      PAYLOAD: if (rx_valid) begin
        crc_d = crc_upd;
        byte_cnt_d = byte_cnt_q + 1'b1;
        payload_valid_d = 1'b1;
        payload_data_d = rx_data;
        state_d = last ? CHECK : PAYLOAD;
      end
      CHECK: if (rx_valid) begin
        frame_done_d = 1'b1;
        frame_ok_d = rx_data == crc_q;
        crc_err_d = rx_data != crc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q <= CRC_INIT;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      frame_len_q <= '0;
      payload_data_q <= '0;
      payload_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      frame_len_q <= frame_len_d;
      payload_data_q <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q <= frame_ok_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      timeout_q <= timeout_d;
    end
  end
  assign payload_data = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign frame_len = frame_len_q;
  assign frame_done = frame_done_q;
  assign frame_ok = frame_ok_q;
  assign crc_err = crc_err_q;
  assign len_err = len_err_q;
  assign timeout = timeout_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_crc_frame_checker.sv
// tb_uart_crc_frame_checker: directed self-checking bench for uart_crc_frame_checker
module tb_uart_crc_frame_checker;
  localparam int T = 20;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] payload_data, frame_len;
  logic payload_valid, frame_done, frame_ok, crc_err, len_err, timeout, busy;
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, tmo_cnt = 0;

  uart_crc_frame_checker #(.MAX_LEN(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .payload_data(payload_data), .payload_valid(payload_valid), .frame_len(frame_len),
    .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err), .len_err(len_err),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (timeout) tmo_cnt++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] len, input logic [7:0] pl, input logic [7:0] c, input logic [1:0] exp);
    send(len);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", nm, busy); else pass_cnt++;
    send(pl);
    total_cnt++;
    if ({payload_valid, payload_data} !== {1'b1, pl}) $display("FAIL %s_pl got %b/%h want 1/%h", nm, payload_valid, payload_data, pl); else pass_cnt++;
    send(c);
    total_cnt++;
    if ({frame_done, frame_ok, crc_err, payload_valid} !== {1'b1, exp, 1'b0}) $display("FAIL %s_done got %b%b%b%b want 1%b0", nm, frame_done, frame_ok, crc_err, payload_valid, exp); else pass_cnt++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++;
    if ({payload_valid, frame_done, frame_ok, crc_err, len_err, timeout, busy, frame_len, payload_data} !== 23'd0)
      $display("FAIL reset_outputs got nonzero (busy=%b len=%h)", busy, frame_len); else pass_cnt++;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_frame9;
    logic [7:0] s;
    send(8'h09);
    for (int i = 0; i < 9; i++) begin
      s = 8'h31 + 8'(i);
      send(s);
      total_cnt++;
      if ({payload_valid, payload_data} !== {1'b1, s}) $display("FAIL f9_pl%0d got %b/%h want 1/%h", i, payload_valid, payload_data, s); else pass_cnt++;
    end
    send(8'hF4);
    total_cnt++;
    if ({frame_done, frame_ok, crc_err, payload_valid} !== 4'b1100) $display("FAIL f9_done got %b%b%b%b want 1100", frame_done, frame_ok, crc_err, payload_valid); else pass_cnt++;
    total_cnt++;
    if (frame_len !== 8'h09) $display("FAIL f9_len got %h want 09", frame_len); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({frame_done, frame_ok, busy} !== 3'b000) $display("FAIL f9_after got %b%b%b want 000", frame_done, frame_ok, busy); else pass_cnt++;
  endtask

  task automatic test_crc;
    check_frame("z", 8'h01, 8'h00, 8'h00, 2'b10);
    idle(1);
    check_frame("one", 8'h01, 8'h01, 8'h07, 2'b10);
    idle(1);
    check_frame("bad", 8'h01, 8'h01, 8'h06, 2'b01);
    idle(1);
  endtask

  task automatic test_len_err;
    send(8'h00);
    total_cnt++;
    if ({len_err, busy, frame_len} !== {2'b10, 8'h00}) $display("FAIL len0 got %b%b/%h want 10/00", len_err, busy, frame_len); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (len_err !== 1'b0) $display("FAIL len0_pulse got %b want 0", len_err); else pass_cnt++;
    send(8'h20);
    total_cnt++;
    if ({len_err, busy} !== 2'b01) $display("FAIL len32 got %b%b want 01", len_err, busy); else pass_cnt++;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    send(8'h21);
    total_cnt++;
    if ({len_err, busy, frame_len} !== {2'b10, 8'h21}) $display("FAIL len33 got %b%b/%h want 10/21", len_err, busy, frame_len); else pass_cnt++;
    check_frame("afterlen", 8'h01, 8'h01, 8'h07, 2'b10);
    idle(1);
  endtask

  task automatic test_timeout;
    int d0, t0;
    d0 = done_cnt;
    send(8'h03);
    send(8'hAA);
    t0 = tmo_cnt;
    idle(T - 1);
    total_cnt++;
    if ({timeout, busy} !== 2'b01 || tmo_cnt != t0) $display("FAIL tmo_early got %b%b cnt %0d want 01 cnt %0d", timeout, busy, tmo_cnt, t0); else pass_cnt++;
    idle(1);
    total_cnt++;
    if ({timeout, busy} !== 2'b10) $display("FAIL tmo_fire got %b%b want 10", timeout, busy); else pass_cnt++;
    idle(T + 5);
    total_cnt++;
    if (tmo_cnt != t0 + 1 || done_cnt != d0) $display("FAIL tmo_single got tmo %0d done %0d want %0d %0d", tmo_cnt, done_cnt, t0 + 1, d0); else pass_cnt++;
    check_frame("aftertmo", 8'h01, 8'h00, 8'h00, 2'b10);
    idle(1);
  endtask

  task automatic test_reset_mid;
    send(8'h05);
    send(8'h11);
    send(8'h22);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({payload_valid, frame_done, frame_ok, crc_err, len_err, timeout, busy, frame_len, payload_data} !== 23'd0)
      $display("FAIL rst_mid got pv=%b busy=%b len=%h data=%h want all 0", payload_valid, busy, frame_len, payload_data); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check_frame("afterrst", 8'h01, 8'h01, 8'h07, 2'b10);
    idle(1);
  endtask

  task automatic test_back_to_back;
    int d0, t0;
    d0 = done_cnt;
    check_frame("b2b_a", 8'h01, 8'h00, 8'h00, 2'b10);
    check_frame("b2b_b", 8'h01, 8'h01, 8'h07, 2'b10);
    @(negedge clk);
    total_cnt++;
    if (done_cnt != d0 + 2) $display("FAIL b2b_count got %0d want %0d", done_cnt - d0, 2); else pass_cnt++;
    t0 = tmo_cnt;
    send(8'h01);
    idle(T - 1);
    send(8'h01);
    total_cnt++;
    if ({payload_valid, payload_data, timeout, busy} !== {1'b1, 8'h01, 2'b01}) $display("FAIL expiry_pl got %b/%h tmo %b busy %b want 1/01 0 1", payload_valid, payload_data, timeout, busy); else pass_cnt++;
    idle(T - 1);
    send(8'h07);
    total_cnt++;
    if ({frame_done, frame_ok, crc_err, timeout} !== 4'b1100 || tmo_cnt != t0) $display("FAIL expiry_crc got %b%b%b%b tmo %0d want 1100 tmo %0d", frame_done, frame_ok, crc_err, timeout, tmo_cnt, t0); else pass_cnt++;
    idle(2);
  endtask

  initial begin
    test_reset;
    test_frame9;
    test_crc;
    test_len_err;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
